// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- central pipeline sequencer for the FMRT Mini Core.
//
// Generates the stall/flush pair for if_reg, id_reg, ex_reg and mem_reg
// from committed exceptions, ERET, memory wait, branch redirects,
// load-use hazards and fetch wait. Only the highest-priority active event
// acts in a cycle. It also latches EPC and the exception code, and drives
// the PC redirect.
//
// Optional build macro: PIPE_CTRL_TIMEOUT_EN
//   defined   -> mem_busy watchdog counter raising TIMEOUT_CODE after
//                MEM_TIMEOUT consecutive busy cycles
//   undefined -> no counter; mem_busy stalls indefinitely
//
// Ports:
//   clk, reset_                    clock, async active-low reset
//   if_busy, mem_busy              fetch not ready / data access pending
//   dec_rs1/rs2_addr, _used        source operands of decode instruction
//   id_is_load, id_rd_addr,
//   id_gpr_we_                     instruction in ID/EX (we is active-low)
//   br_taken, br_target            EX-resolved redirect
//   mem_exp_code, mem_pc, mem_eret instruction in ex_reg
//   {if,id,ex,mem}_stall/_flush    per-register hold / clear
//   new_pc, new_pc_en              redirect address / valid
//   epc, exp_code, exc_active      saved exception state

`ifndef REG_ADDR_BUS
`define REG_ADDR_BUS 4:0
`endif
`ifndef WORD_DATA_BUS
`define WORD_DATA_BUS 31:0
`endif
`ifndef EXP_CODE_BUS
`define EXP_CODE_BUS 2:0
`endif
`ifndef EXP_NO_EXP
`define EXP_NO_EXP 3'h0
`endif

module pipe_ctrl #(
  parameter logic [`WORD_DATA_BUS] EXP_VECTOR   = 32'h0000_0100,
  parameter int                    MEM_TIMEOUT  = 16,
  parameter logic [`EXP_CODE_BUS]  TIMEOUT_CODE = 3'd1
) (
  input  logic                  clk,
  input  logic                  reset_,
  input  logic                  if_busy,
  input  logic                  mem_busy,
  input  logic [`REG_ADDR_BUS]  dec_rs1_addr,
  input  logic [`REG_ADDR_BUS]  dec_rs2_addr,
  input  logic                  dec_rs1_used,
  input  logic                  dec_rs2_used,
  input  logic                  id_is_load,
  input  logic [`REG_ADDR_BUS]  id_rd_addr,
  input  logic                  id_gpr_we_,
  input  logic                  br_taken,
  input  logic [`WORD_DATA_BUS] br_target,
  input  logic [`EXP_CODE_BUS]  mem_exp_code,
  input  logic [`WORD_DATA_BUS] mem_pc,
  input  logic                  mem_eret,
  output logic                  if_stall,
  output logic                  id_stall,
  output logic                  ex_stall,
  output logic                  mem_stall,
  output logic                  if_flush,
  output logic                  id_flush,
  output logic                  ex_flush,
  output logic                  mem_flush,
  output logic [`WORD_DATA_BUS] new_pc,
  output logic                  new_pc_en,
  output logic [`WORD_DATA_BUS] epc,
  output logic [`EXP_CODE_BUS]  exp_code,
  output logic                  exc_active
);

  typedef enum logic {
    RUN     = 1'b0,
    HANDLER = 1'b1
  } state_t;

  state_t                  state, state_nxt;
  logic [`WORD_DATA_BUS]   epc_nxt;
  logic [`EXP_CODE_BUS]    exp_code_nxt;
  logic                    timeout_fire;
  logic                    exc_take;
  logic                    load_use;

`ifdef PIPE_CTRL_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

  logic [7:0] busy_cnt, busy_cnt_nxt;

  assign timeout_fire = mem_busy && (busy_cnt == TIMEOUT_LAST);

  // Cleared on exception entry and on any non-busy cycle; saturates so a
  // very long stall in HANDLER cannot wrap back to a small count.
  always_comb begin
    busy_cnt_nxt = busy_cnt;
    if (exc_take || !mem_busy) begin
      busy_cnt_nxt = '0;
    end else if (busy_cnt != 8'hFF) begin
      busy_cnt_nxt = busy_cnt + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      busy_cnt <= '0;
    end else begin
      busy_cnt <= busy_cnt_nxt;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^MEM_TIMEOUT;
  assign timeout_fire       = 1'b0;
`endif

  assign exc_take = (mem_exp_code != `EXP_NO_EXP) || timeout_fire;

  // rd==0 never creates a hazard since x0 is never actually written.
  assign load_use = id_is_load && !id_gpr_we_ && (id_rd_addr != '0) &&
                    ((dec_rs1_used && (dec_rs1_addr == id_rd_addr)) ||
                     (dec_rs2_used && (dec_rs2_addr == id_rd_addr)));

  always_comb begin
    if_stall     = 1'b0;
    id_stall     = 1'b0;
    ex_stall     = 1'b0;
    mem_stall    = 1'b0;
    if_flush     = 1'b0;
    id_flush     = 1'b0;
    ex_flush     = 1'b0;
    mem_flush    = 1'b0;
    new_pc       = '0;
    new_pc_en    = 1'b0;
    state_nxt    = state;
    epc_nxt      = epc;
    exp_code_nxt = exp_code;

    if (exc_take) begin
      // A real fault code wins over a simultaneous watchdog expiry.
      if_flush     = 1'b1;
      id_flush     = 1'b1;
      ex_flush     = 1'b1;
      mem_flush    = 1'b1;
      new_pc       = EXP_VECTOR;
      new_pc_en    = 1'b1;
      epc_nxt      = mem_pc;
      exp_code_nxt = (mem_exp_code != `EXP_NO_EXP) ? mem_exp_code : TIMEOUT_CODE;
      state_nxt    = HANDLER;
    end else if (mem_eret && (state == HANDLER)) begin
      if_flush     = 1'b1;
      id_flush     = 1'b1;
      ex_flush     = 1'b1;
      mem_flush    = 1'b1;
      new_pc       = epc;
      new_pc_en    = 1'b1;
      exp_code_nxt = `EXP_NO_EXP;
      state_nxt    = RUN;
    end else if (mem_busy) begin
      if_stall  = 1'b1;
      id_stall  = 1'b1;
      ex_stall  = 1'b1;
      mem_stall = 1'b1;
    end else if (br_taken) begin
      if_flush  = 1'b1;
      id_flush  = 1'b1;
      new_pc    = br_target;
      new_pc_en = 1'b1;
    end else if (load_use) begin
      // Hold the consumer in IF/ID and inject one bubble into ID/EX; the
      // bubble removes the load from ID/EX, so this ends after one cycle.
      if_stall = 1'b1;
      id_flush = 1'b1;
    end else if (if_busy) begin
      if_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state    <= RUN;
      epc      <= '0;
      exp_code <= `EXP_NO_EXP;
    end else begin
      state    <= state_nxt;
      epc      <= epc_nxt;
      exp_code <= exp_code_nxt;
    end
  end

  assign exc_active = (state == HANDLER);

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: a priority-rule model checked every
// negative clock edge, plus directed literal expectations.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        reset_;
  logic        if_busy, mem_busy;
  logic [4:0]  dec_rs1_addr, dec_rs2_addr, id_rd_addr;
  logic        dec_rs1_used, dec_rs2_used, id_is_load, id_gpr_we_;
  logic        br_taken;
  logic [31:0] br_target, mem_pc;
  logic [2:0]  mem_exp_code;
  logic        mem_eret;
  logic        if_stall, id_stall, ex_stall, mem_stall;
  logic        if_flush, id_flush, ex_flush, mem_flush;
  logic [31:0] new_pc, epc;
  logic        new_pc_en, exc_active;
  logic [2:0]  exp_code;

  int checks   = 0;
  int failures = 0;

  pipe_ctrl dut (
    .clk(clk), .reset_(reset_), .if_busy(if_busy), .mem_busy(mem_busy),
    .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .id_is_load(id_is_load), .id_rd_addr(id_rd_addr), .id_gpr_we_(id_gpr_we_),
    .br_taken(br_taken), .br_target(br_target),
    .mem_exp_code(mem_exp_code), .mem_pc(mem_pc), .mem_eret(mem_eret),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .new_pc(new_pc), .new_pc_en(new_pc_en), .epc(epc), .exp_code(exp_code),
    .exc_active(exc_active)
  );

  always #5 clk = ~clk;

  // ---------------- model ----------------
  logic        m_handler;
  logic [31:0] m_epc;
  logic [2:0]  m_code;
  int          m_busy_run;

  function automatic bit m_timeout();
`ifdef PIPE_CTRL_TIMEOUT_EN
    return mem_busy && (m_busy_run == 16 - 1);
`else
    return 1'b0;
`endif
  endfunction

  // Winning event: 1 exc, 2 eret, 3 busy, 4 branch, 5 load-use, 6 if_busy, 0 none
  function automatic int m_event();
    bit hz;
    hz = id_is_load && !id_gpr_we_ && id_rd_addr != 0 &&
         ((dec_rs1_used && dec_rs1_addr == id_rd_addr) ||
          (dec_rs2_used && dec_rs2_addr == id_rd_addr));
    if (mem_exp_code != 0 || m_timeout()) return 1;
    if (mem_eret && m_handler)            return 2;
    if (mem_busy)                         return 3;
    if (br_taken)                         return 4;
    if (hz)                               return 5;
    if (if_busy)                          return 6;
    return 0;
  endfunction

  // st/fl bit order: {mem, ex, id, if}
  task automatic m_outputs(output logic [3:0] st, output logic [3:0] fl,
                           output logic en, output logic [31:0] pc);
    st = 4'b0000; fl = 4'b0000; en = 1'b0; pc = 32'h0;
    case (m_event())
      1: begin fl = 4'b1111; en = 1'b1; pc = 32'h0000_0100; end
      2: begin fl = 4'b1111; en = 1'b1; pc = m_epc; end
      3: st = 4'b1111;
      4: begin fl = 4'b0011; en = 1'b1; pc = br_target; end
      5: begin st = 4'b0001; fl = 4'b0010; end
      6: fl = 4'b0001;
      default: ;
    endcase
  endtask

  always @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      m_handler  <= 1'b0;
      m_epc      <= 32'h0;
      m_code     <= 3'h0;
      m_busy_run <= 0;
    end else begin
      int ev;
      ev = m_event();
      if (ev == 1) begin
        m_handler  <= 1'b1;
        m_epc      <= mem_pc;
        m_code     <= (mem_exp_code != 0) ? mem_exp_code : 3'd1;
        m_busy_run <= 0;
      end else begin
        if (ev == 2) begin
          m_handler <= 1'b0;
          m_code    <= 3'h0;
        end
        m_busy_run <= mem_busy ? ((m_busy_run < 255) ? m_busy_run + 1 : 255) : 0;
      end
    end
  end

  // ---------------- every-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0]  est, efl;
    logic        een;
    logic [31:0] epcx;
    m_outputs(est, efl, een, epcx);
    checks++;
    if ({mem_stall, ex_stall, id_stall, if_stall} !== est) begin
      failures++;
      $display("FAIL cyc_stall t=%0t got=%b exp=%b", $time,
               {mem_stall, ex_stall, id_stall, if_stall}, est);
    end
    checks++;
    if ({mem_flush, ex_flush, id_flush, if_flush} !== efl) begin
      failures++;
      $display("FAIL cyc_flush t=%0t got=%b exp=%b", $time,
               {mem_flush, ex_flush, id_flush, if_flush}, efl);
    end
    checks++;
    if (new_pc_en !== een || new_pc !== epcx) begin
      failures++;
      $display("FAIL cyc_newpc t=%0t got=%b/%h exp=%b/%h", $time, new_pc_en, new_pc, een, epcx);
    end
    checks++;
    if (epc !== m_epc || exp_code !== m_code || exc_active !== m_handler) begin
      failures++;
      $display("FAIL cyc_state t=%0t got=%h/%0d/%b exp=%h/%0d/%b", $time,
               epc, exp_code, exc_active, m_epc, m_code, m_handler);
    end
  end

  // ---------------- directed ----------------
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if_busy = 0; mem_busy = 0; dec_rs1_addr = 0; dec_rs2_addr = 0;
    dec_rs1_used = 0; dec_rs2_used = 0; id_is_load = 0; id_rd_addr = 0;
    id_gpr_we_ = 1; br_taken = 0; br_target = 0; mem_exp_code = 0;
    mem_pc = 0; mem_eret = 0;
  endtask

  initial begin
    reset_ = 1'b0;
    clear_inputs();
    #2;
    chk("rst_epc", epc, 32'h0);
    chk("rst_code", {29'b0, exp_code}, 32'h0);
    chk("rst_active", {31'b0, exc_active}, 32'h0);
    chk("rst_newpc_en", {31'b0, new_pc_en}, 32'h0);
    step(); step();
    reset_ = 1'b1;
    step();

    // load-use on rs1
    id_is_load = 1; id_gpr_we_ = 0; id_rd_addr = 5; dec_rs1_used = 1; dec_rs1_addr = 5;
    #2;
    chk("lu_if_stall", {31'b0, if_stall}, 32'h1);
    chk("lu_id_flush", {31'b0, id_flush}, 32'h1);
    step();
    id_is_load = 0;
    #2 chk("lu_after", {31'b0, if_stall}, 32'h0);
    step();
    // rd = 0 never hazards
    id_is_load = 1; id_rd_addr = 0; dec_rs1_addr = 0;
    #2 chk("lu_rd0", {31'b0, if_stall}, 32'h0);
    step();
    // rs2 match, rs1 unused
    id_rd_addr = 7; dec_rs1_used = 0; dec_rs2_used = 1; dec_rs2_addr = 7;
    #2 chk("lu_rs2", {30'b0, id_flush, if_stall}, 32'h3);
    step();
    clear_inputs();
    if_busy = 1;
    #2 chk("ifbusy_flush", {28'b0, mem_flush, ex_flush, id_flush, if_flush}, 32'h1);
    step();
    clear_inputs();

    // branch
    br_taken = 1; br_target = 32'h0000_0040;
    #2;
    chk("br_pc", new_pc, 32'h40);
    chk("br_en", {31'b0, new_pc_en}, 32'h1);
    chk("br_flush", {28'b0, mem_flush, ex_flush, id_flush, if_flush}, 32'h3);
    step();
    // busy outranks branch
    mem_busy = 1;
    #2;
    chk("busy_br_stall", {28'b0, mem_stall, ex_stall, id_stall, if_stall}, 32'hF);
    chk("busy_br_en", {31'b0, new_pc_en}, 32'h0);
    step();
    clear_inputs();

    // ERET in RUN is a NOP
    mem_eret = 1;
    #2 chk("eret_run_nop", {31'b0, new_pc_en}, 32'h0);
    step();
    clear_inputs();

    // exception and return
    mem_exp_code = 2; mem_pc = 32'h0000_0020;
    #2;
    chk("exc_flush", {28'b0, mem_flush, ex_flush, id_flush, if_flush}, 32'hF);
    chk("exc_pc", new_pc, 32'h100);
    step();
    clear_inputs();
    #2;
    chk("exc_epc", epc, 32'h20);
    chk("exc_code", {29'b0, exp_code}, 32'h2);
    chk("exc_active", {31'b0, exc_active}, 32'h1);
    mem_eret = 1;
    #1 chk("eret_pc", new_pc, 32'h20);
    step();
    clear_inputs();
    #2;
    chk("eret_active", {31'b0, exc_active}, 32'h0);
    chk("eret_code", {29'b0, exp_code}, 32'h0);
    step();

    // fault outranks busy
    mem_exp_code = 3; mem_busy = 1; mem_pc = 32'h0000_0028;
    #2;
    chk("fault_busy_en", {31'b0, new_pc_en}, 32'h1);
    chk("fault_busy_stall", {28'b0, mem_stall, ex_stall, id_stall, if_stall}, 32'h0);
    step();
    clear_inputs();
    #2 chk("fault_busy_code", {29'b0, exp_code}, 32'h3);
    mem_eret = 1;
    step();
    clear_inputs();
    step();

    // watchdog
    mem_busy = 1; mem_pc = 32'h0000_0044;
`ifdef PIPE_CTRL_TIMEOUT_EN
    for (int k = 1; k <= 16; k++) begin
      #2;
      if (k < 16) chk("to_stall", {28'b0, mem_stall, ex_stall, id_stall, if_stall}, 32'hF);
      else        chk("to_fire_pc", {new_pc_en ? new_pc : 32'hFFFF_FFFF}, 32'h100);
      step();
    end
    mem_busy = 0;
    #2;
    chk("to_code", {29'b0, exp_code}, 32'h1);
    chk("to_epc", epc, 32'h44);
    mem_eret = 1;
    step();
    clear_inputs();
`else
    begin
      int stalled;
      stalled = 0;
      for (int k = 1; k <= 110; k++) begin
        #2;
        if ({mem_stall, ex_stall, id_stall, if_stall} == 4'hF && !new_pc_en) stalled++;
        step();
      end
      chk("no_to_stalls", stalled, 32'd110);
    end
    mem_busy = 0;
    #2 chk("no_to_active", {31'b0, exc_active}, 32'h0);
`endif
    step();

    // async reset while in HANDLER
    mem_exp_code = 5; mem_pc = 32'h0000_0030;
    step();
    clear_inputs();
    #1 chk("pre_rst_active", {31'b0, exc_active}, 32'h1);
    #1 reset_ = 1'b0;
    #1;
    chk("arst_active", {31'b0, exc_active}, 32'h0);
    chk("arst_epc", epc, 32'h0);
    chk("arst_code", {29'b0, exp_code}, 32'h0);
    step();
    reset_ = 1'b1;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline sequencer for the FMRT Mini Core. Generates the stall/flush pair for each pipeline register (if_reg, id_reg, ex_reg, mem_reg) from hazards, branch redirects, memory wait and committed exceptions. Latches EPC and the exception code, and drives the PC redirect.
Convention: X_stall/X_flush control the register whose outputs carry the X_ prefix. Stall outranks flush inside each register.

Parameters:
EXP_VECTOR, 32'h0000_0100, handler entry address
MEM_TIMEOUT, 16, consecutive mem_busy cycles that trigger a bus-timeout exception (range 2..255)
TIMEOUT_CODE, 1, exception code raised on timeout (`EXP_CODE_BUS width)

Ports:
clk  in  1  clock
reset_  in  1  asynchronous, active-low reset
if_busy  in  1  instruction fetch not ready; fetch unit holds PC itself
mem_busy  in  1  data access pending in MEM
dec_rs1_addr  in  `REG_ADDR_BUS  rs1 of instruction in decode
dec_rs2_addr  in  `REG_ADDR_BUS  rs2 of instruction in decode
dec_rs1_used  in  1  rs1 read by decode instruction
dec_rs2_used  in  1  rs2 read by decode instruction
id_is_load  in  1  instruction in ID/EX is a load
id_rd_addr  in  `REG_ADDR_BUS  its destination
id_gpr_we_  in  1  its write enable, active-low
br_taken  in  1  EX-resolved taken branch/jump
br_target  in  `WORD_DATA_BUS  branch target
mem_exp_code  in  `EXP_CODE_BUS  exception of instruction in ex_reg
mem_pc  in  `WORD_DATA_BUS  its PC
mem_eret  in  1  instruction in ex_reg is ERET
if_stall, id_stall, ex_stall, mem_stall  out  1 each  register hold
if_flush, id_flush, ex_flush, mem_flush  out  1 each  register clear
new_pc  out  `WORD_DATA_BUS  redirect address
new_pc_en  out  1  redirect valid this cycle
epc  out  `WORD_DATA_BUS  saved exception PC
exp_code  out  `EXP_CODE_BUS  saved exception code
exc_active  out  1  handler running

Behaviour:
- Reset (reset_=0, async): epc=0, exp_code=`EXP_NO_EXP, exc_active=0, state=RUN, timeout counter=0. All combinational outputs evaluate from these values.
- Stall, flush, new_pc and new_pc_en are combinational from the current inputs and state, with zero latency. epc, exp_code, exc_active and the counter update on posedge clk.
- Events are evaluated in strict priority order; only the highest active event acts in a cycle.
  - 1. Exception (mem_exp_code != `EXP_NO_EXP, or timeout fires):
    - All four flushes=1, all stalls=0.
    - new_pc=EXP_VECTOR, new_pc_en=1.
    - At the clock edge: epc<=mem_pc, exp_code<=code, state<=HANDLER, counter<=0.
    - An exception in HANDLER is also taken and overwrites epc (no nesting support).
    - mem_exp_code outranks mem_busy: a faulting access is not waited on.
  - 2. mem_eret while in HANDLER:
    - All four flushes=1, new_pc=epc, new_pc_en=1.
    - At the edge: state<=RUN, exp_code<=`EXP_NO_EXP.
    - mem_eret in RUN is treated as a NOP.
  - 3. mem_busy: all four stalls=1, no flushes, counter increments (saturating at 255).
  - 4. br_taken: if_flush=1 and id_flush=1, new_pc=br_target, new_pc_en=1.
  - 5. Load-use: all of the following hold:
    - id_is_load && !id_gpr_we_ && id_rd_addr!=0
    - and either (dec_rs1_used && dec_rs1_addr==id_rd_addr) or the same test for rs2.
    - Response: if_stall=1, id_flush=1 (one bubble), for exactly one cycle per hazard.
  - 6. if_busy: if_flush=1 (bubble into IF/ID).
- Counter clears on any cycle with mem_busy=0.
- Timeout fires when mem_busy=1 && counter==MEM_TIMEOUT-1. It raises TIMEOUT_CODE at priority 1 and sets epc=mem_pc.
- exc_active = (state==HANDLER).
- new_pc holds 0 whenever new_pc_en=0.
- Reset asserted mid-stall or mid-handler returns to RUN immediately.

Optional Feature:
PIPE_CTRL_TIMEOUT_EN:
- Defined: the mem_busy watchdog counter and TIMEOUT_CODE exception are built.
- Undefined: the counter is absent, mem_busy stalls indefinitely, and MEM_TIMEOUT/TIMEOUT_CODE are unused.

Test Plan:
- Load-use: id_is_load=1, id_gpr_we_=0, id_rd_addr=5, dec_rs1_used=1, dec_rs1_addr=5 -> if_stall=1, id_flush=1 for one cycle; with id_rd_addr=0 -> no stall.
- Branch: br_taken=1, br_target=32'h0000_0040 -> new_pc_en=1, new_pc=32'h40, if_flush=id_flush=1, ex_flush=mem_flush=0.
- Exception: mem_exp_code=2, mem_pc=32'h0000_0020 -> all flushes=1, new_pc=32'h100; next cycle epc=32'h20, exp_code=2, exc_active=1. Then mem_eret=1 -> new_pc=32'h20, exc_active=0 after the edge.
- Priority: mem_busy=1 with br_taken=1 -> all stalls=1, new_pc_en=0; mem_exp_code=3 with mem_busy=1 -> exception taken.
- Timeout (PIPE_CTRL_TIMEOUT_EN, MEM_TIMEOUT=16): mem_busy held high -> stalls on cycles 1-15, exception on cycle 16 with exp_code=TIMEOUT_CODE. Without the macro -> stalls persist past 100 cycles.
- Async reset asserted in HANDLER mid-cycle -> exc_active=0, epc=0, exp_code=`EXP_NO_EXP immediately, without waiting for a clock edge.
